// File: rtl/decoder_scan.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with enable, direct mode and
// auto-scan mode stepping the active output through 0..SCAN_LAST every DIV clocks.
module decoder_scan #(
    parameter int unsigned SEL_W      = 3,
    parameter int unsigned DIV        = 4,
    parameter int unsigned SCAN_LAST  = 2**SEL_W - 1,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    load,
    output logic [(2**SEL_W)-1:0]   d,
    output logic [SEL_W-1:0]        cur_sel,
    output logic                    wrap
);

    localparam int unsigned OUT_W = 2**SEL_W;
    localparam int unsigned PW    = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PW-1:0]    PRESC_MAX = PW'(DIV - 1);
    localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(SCAN_LAST);
    localparam logic [OUT_W-1:0] INACTIVE  = {OUT_W{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIRECT,
        ST_SCAN
    } state_t;

    state_t           state_q,   state_d;
    logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
    logic [PW-1:0]    presc_q,   presc_d;
    logic [OUT_W-1:0] d_q,       d_d;
    logic             wrap_q,    wrap_d;

    function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] idx);
        return (OUT_W'(1) << idx) ^ INACTIVE;
    endfunction

    always_comb begin
        state_d   = state_q;
        cur_sel_d = cur_sel_q;
        presc_d   = presc_q;
        d_d       = d_q;
        wrap_d    = 1'b0;

        if (!en) begin
            state_d = ST_IDLE;
            presc_d = '0;
            d_d     = INACTIVE;
        end else if (!mode) begin
            state_d   = ST_DIRECT;
            cur_sel_d = sel;
            presc_d   = '0;
            d_d       = decode(sel);
        end else begin
            state_d = ST_SCAN;
            // Entry and load both restart from sel; load wins over a due step.
            if (state_q != ST_SCAN || load) begin
                cur_sel_d = sel;
                presc_d   = '0;
            end else if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                if (cur_sel_q >= LAST_IDX) begin
                    cur_sel_d = '0;
                    wrap_d    = 1'b1;
                end else begin
                    cur_sel_d = cur_sel_q + SEL_W'(1);
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
            d_d = decode(cur_sel_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cur_sel_q <= '0;
            presc_q   <= '0;
            d_q       <= INACTIVE;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_sel_q <= cur_sel_d;
            presc_q   <= presc_d;
            d_q       <= d_d;
            wrap_q    <= wrap_d;
        end
    end

    assign d       = d_q;
    assign cur_sel = cur_sel_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Scoreboard bench for decoder_scan: three instances (default, SCAN_LAST=4/DIV=1,
// active-low) share inputs; expectations are queued per cycle and checked at negedge.
module tb_decoder_scan;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic [2:0] sel = '0;
    logic       load = 1'b0;

    logic [7:0] d0, d1, d2;
    logic [2:0] cs0, cs1, cs2;
    logic       w0, w1, w2;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        int         cyc;
        int         id;
        logic [7:0] d;
        logic [2:0] cs;
        logic       w;
        string      name;
    } exp_t;

    exp_t q[$];

    decoder_scan #(.SEL_W(3), .DIV(4), .SCAN_LAST(7), .ACTIVE_LOW(1'b0)) u_main (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .load(load),
        .d(d0), .cur_sel(cs0), .wrap(w0)
    );

    decoder_scan #(.SEL_W(3), .DIV(1), .SCAN_LAST(4), .ACTIVE_LOW(1'b0)) u_bnd (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .load(load),
        .d(d1), .cur_sel(cs1), .wrap(w1)
    );

    decoder_scan #(.SEL_W(3), .DIV(4), .SCAN_LAST(7), .ACTIVE_LOW(1'b1)) u_low (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .load(load),
        .d(d2), .cur_sel(cs2), .wrap(w2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic [11:0] act, req;
            e = q.pop_front();
            case (e.id)
                0:       act = {d0, cs0, w0};
                1:       act = {d1, cs1, w1};
                default: act = {d2, cs2, w2};
            endcase
            req = {e.d, e.cs, e.w};
            total++;
            if (e.cyc != cyc) begin
                bad++;
                $display("FAIL %s dut%0d: expectation for cycle %0d not checked in time (now %0d)",
                         e.name, e.id, e.cyc, cyc);
            end else if (act !== req) begin
                bad++;
                $display("FAIL %s dut%0d cyc%0d: got d=%h cur_sel=%0d wrap=%b, want d=%h cur_sel=%0d wrap=%b",
                         e.name, e.id, cyc, act[11:4], act[3:1], act[0], e.d, e.cs, e.w);
            end
        end
    end

    task automatic drive(input logic e_i, input logic m_i, input logic [2:0] s_i, input logic l_i);
        @(posedge clk);
        #1;
        en   = e_i;
        mode = m_i;
        sel  = s_i;
        load = l_i;
    endtask

    task automatic hold();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_next(input int id, input logic [7:0] dv, input logic [2:0] csv,
                               input logic wv, input string nm);
        q.push_back('{cyc + 1, id, dv, csv, wv, nm});
    endtask

    task automatic expect_now(input int id, input logic [7:0] dv, input logic [2:0] csv,
                              input logic wv, input string nm);
        q.push_back('{cyc, id, dv, csv, wv, nm});
    endtask

    initial begin
        logic [7:0] oh;

        // Reset release with en=0: everything stays at reset values
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            expect_next(0, 8'h00, 3'd0, 1'b0, "rst_idle");
            expect_next(2, 8'hFF, 3'd0, 1'b0, "rst_idle_low");
            hold();
        end

        // Direct sweep, both polarities
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 3'(i), 1'b0);
            oh = 8'h01 << i;
            expect_next(0, oh, 3'(i), 1'b0, "direct");
            expect_next(2, ~oh, 3'(i), 1'b0, "direct_low");
        end
        drive(1'b0, 1'b0, 3'd0, 1'b0);
        expect_next(0, 8'h00, 3'd7, 1'b0, "direct_off");
        expect_next(2, 8'hFF, 3'd7, 1'b0, "direct_off_low");

        // Asynchronous reset in mid-cycle
        drive(1'b1, 1'b0, 3'd5, 1'b0);
        expect_next(0, 8'h20, 3'd5, 1'b0, "pre_async");
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        expect_now(0, 8'h00, 3'd0, 1'b0, "async_rst");
        expect_now(2, 8'hFF, 3'd0, 1'b0, "async_rst_low");
        drive(1'b0, 1'b0, 3'd0, 1'b0);
        rst_n = 1'b1;
        expect_next(0, 8'h00, 3'd0, 1'b0, "post_rst");
        hold();
        expect_next(0, 8'h00, 3'd0, 1'b0, "post_rst");

        // Scan from 6 with DIV=4
        drive(1'b1, 1'b1, 3'd6, 1'b0);
        for (int k = 1; k <= 13; k++) begin
            if (k > 1) hold();
            if (k <= 4)       expect_next(0, 8'h40, 3'd6, 1'b0, "scan6");
            else if (k <= 8)  expect_next(0, 8'h80, 3'd7, 1'b0, "scan7");
            else if (k == 9)  expect_next(0, 8'h01, 3'd0, 1'b1, "scan_wrap");
            else if (k <= 12) expect_next(0, 8'h01, 3'd0, 1'b0, "scan0");
            else              expect_next(0, 8'h02, 3'd1, 1'b0, "scan1");
        end
        drive(1'b0, 1'b0, 3'd0, 1'b0);
        expect_next(0, 8'h00, 3'd1, 1'b0, "scan_off_hold");

        // Load coincident with a due step
        drive(1'b1, 1'b1, 3'd0, 1'b0);
        expect_next(0, 8'h01, 3'd0, 1'b0, "ld_pre");
        for (int k = 2; k <= 4; k++) begin
            hold();
            expect_next(0, 8'h01, 3'd0, 1'b0, "ld_pre");
        end
        drive(1'b1, 1'b1, 3'd2, 1'b1);
        expect_next(0, 8'h04, 3'd2, 1'b0, "load");
        drive(1'b1, 1'b1, 3'd2, 1'b0);
        expect_next(0, 8'h04, 3'd2, 1'b0, "ld_hold");
        for (int k = 0; k < 2; k++) begin
            hold();
            expect_next(0, 8'h04, 3'd2, 1'b0, "ld_hold");
        end
        hold();
        expect_next(0, 8'h08, 3'd3, 1'b0, "ld_step");
        drive(1'b0, 1'b0, 3'd0, 1'b0);

        // Bounds: SCAN_LAST=4, DIV=1, entry above SCAN_LAST
        drive(1'b1, 1'b1, 3'd6, 1'b0);
        expect_next(1, 8'h40, 3'd6, 1'b0, "bnd6");
        hold(); expect_next(1, 8'h01, 3'd0, 1'b1, "bnd_wrap6");
        hold(); expect_next(1, 8'h02, 3'd1, 1'b0, "bnd1");
        hold(); expect_next(1, 8'h04, 3'd2, 1'b0, "bnd2");
        hold(); expect_next(1, 8'h08, 3'd3, 1'b0, "bnd3");
        hold(); expect_next(1, 8'h10, 3'd4, 1'b0, "bnd4");
        hold(); expect_next(1, 8'h01, 3'd0, 1'b1, "bnd_wrap4");
        drive(1'b0, 1'b0, 3'd0, 1'b0);

        // Mode toggle mid-step restarts the scan from sel
        drive(1'b1, 1'b1, 3'd4, 1'b0);
        expect_next(0, 8'h10, 3'd4, 1'b0, "tog_scan");
        hold();
        expect_next(0, 8'h10, 3'd4, 1'b0, "tog_scan");
        drive(1'b1, 1'b0, 3'd4, 1'b0);
        expect_next(0, 8'h10, 3'd4, 1'b0, "tog_direct");
        drive(1'b1, 1'b1, 3'd4, 1'b0);
        expect_next(0, 8'h10, 3'd4, 1'b0, "tog_reenter");
        for (int k = 0; k < 3; k++) begin
            hold();
            expect_next(0, 8'h10, 3'd4, 1'b0, "tog_hold");
        end
        hold();
        expect_next(0, 8'h20, 3'd5, 1'b0, "tog_step");

        repeat (3) @(posedge clk);
        #1;
        if (q.size() != 0) begin
            $display("FAIL drain: %0d expectations never checked, want 0", q.size());
            $fatal(1, "scoreboard not drained");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached, want finish before it");
        $fatal(1, "timeout");
    end

endmodule
